tb_doutb_map: RTL

- Read-side counterpart of the temp-buffer (TB) write-data mapper.
- Accepts a burst-read command, generates TB port-B read enable and addresses, and delays the lane-mapping select to match the BRAM read latency.
- Remaps each L-lane read word by direction: POS straight, NEG lane-reversed, NEW half-extraction by l_k_0.
- Delivers the mapped word with a valid strobe to the CB write path or to the non-linear unit input.

---
 rtl/tb_doutb_map.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/tb_doutb_map.sv
// Temp-buffer port-B burst reader: issues enables/addresses, aligns to read latency, remaps lanes by direction.
// Optional macro TB_RD_STRIDE_EN adds a latched rd_stride address step (otherwise the step is 1).
module tb_doutb_map #(
    parameter int L               = 4,
    parameter int RSA_DW          = 32,
    parameter int TB_AW           = 10,
    parameter int RD_LAT          = 2,
    parameter int TB_DOUTB_SEL_DW = 3
) (
    input  logic                              clk,
    input  logic                              sys_rst,
    input  logic                              rd_start,
    input  logic [TB_AW-1:0]                  rd_base_addr,
    input  logic [TB_AW-1:0]                  rd_len,
    input  logic [TB_DOUTB_SEL_DW-1:0]        rd_sel,
    input  logic                              l_k_0,
`ifdef TB_RD_STRIDE_EN
    input  logic [TB_AW-1:0]                  rd_stride,
`endif
    output logic                              rd_busy,
    output logic                              rd_done,
    output logic                              TB_enb,
    output logic [TB_AW-1:0]                  TB_addrb,
    input  logic signed [L*RSA_DW-1:0]        TB_doutb,
    output logic signed [L*RSA_DW-1:0]        CB_dina,
    output logic                              CB_dina_vld,
    output logic signed [L*RSA_DW-1:0]        NL_din,
    output logic                              NL_din_vld
);

    // rd_start is a one-cycle command taken only in IDLE; *_vld are one-cycle data qualifiers with no backpressure.
    localparam int         W       = L * RSA_DW;
    localparam int         DST_BIT = 2;
    localparam logic [1:0] DIR_POS = 2'b01;
    localparam logic [1:0] DIR_NEG = 2'b10;
    localparam logic [1:0] DIR_NEW = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [TB_DOUTB_SEL_DW-1:0] sel_q, sel_d;
    logic                       lk_q, lk_d;
    logic [TB_AW-1:0]           len_q, len_d;
    logic [TB_AW-1:0]           stride_q, stride_d;
    logic [TB_AW-1:0]           beat_q, beat_d;
    logic [TB_AW-1:0]           addr_q, addr_d;
    logic                       enb_q, enb_d;
    logic                       done_q, done_d;
    logic [RD_LAT-1:0]          vld_sr_q, vld_sr_d;
    logic                       stage_q, stage_d;
    logic [W-1:0]               cb_dat_q, cb_dat_d;
    logic [W-1:0]               nl_dat_q, nl_dat_d;
    logic                       cb_vld_q, cb_vld_d;
    logic                       nl_vld_q, nl_vld_d;
    logic [W-1:0]               mapped;
    logic                       word_vld;
    logic [TB_AW-1:0]           stride_in;

`ifdef TB_RD_STRIDE_EN
    assign stride_in = rd_stride;
`else
    assign stride_in = TB_AW'(1);
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        lk_d     = lk_q;
        len_d    = len_q;
        stride_d = stride_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        enb_d    = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_start) begin
                    sel_d    = rd_sel;
                    lk_d     = l_k_0;
                    len_d    = rd_len;
                    stride_d = stride_in;
                    addr_d   = rd_base_addr;
                    if (rd_len != '0) begin
                        state_d = S_READ;
                        enb_d   = 1'b1;
                        beat_d  = TB_AW'(1);
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            // beat_q counts enables already on the bus, so equality means the last one is out now.
            S_READ: begin
                if (beat_q == len_q) begin
                    state_d = S_DRAIN;
                end else begin
                    enb_d  = 1'b1;
                    beat_d = beat_q + TB_AW'(1);
                    addr_d = addr_q + stride_q;
                end
            end
            S_DRAIN: begin
                if (vld_sr_q == '0 && !stage_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                beat_d  = '0;
                addr_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vld_sr_d[0] = enb_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end
    end

    // Select and l_k_0 are latched for the whole burst, so they line up with every returning word.
    always_comb begin
        mapped = '0;
        case (sel_q[1:0])
            DIR_POS: mapped = TB_doutb;
            DIR_NEG: begin
                for (int i = 0; i < L; i++) begin
                    mapped[i*RSA_DW +: RSA_DW] = TB_doutb[(L-1-i)*RSA_DW +: RSA_DW];
                end
            end
            DIR_NEW: begin
                for (int i = 0; i < L/2; i++) begin
                    mapped[i*RSA_DW +: RSA_DW] = lk_q ? TB_doutb[i*RSA_DW +: RSA_DW]
                                                      : TB_doutb[(i+L/2)*RSA_DW +: RSA_DW];
                end
            end
            default: mapped = '0;
        endcase
    end

    always_comb begin
        stage_d  = vld_sr_q[RD_LAT-1];
        word_vld = vld_sr_q[RD_LAT-1] && (sel_q[1:0] != 2'b00);
        cb_vld_d = word_vld && !sel_q[DST_BIT];
        nl_vld_d = word_vld &&  sel_q[DST_BIT];
        cb_dat_d = cb_vld_d ? mapped : '0;
        nl_dat_d = nl_vld_d ? mapped : '0;
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            lk_q     <= 1'b0;
            len_q    <= '0;
            stride_q <= '0;
            beat_q   <= '0;
            addr_q   <= '0;
            enb_q    <= 1'b0;
            done_q   <= 1'b0;
            vld_sr_q <= '0;
            stage_q  <= 1'b0;
            cb_dat_q <= '0;
            nl_dat_q <= '0;
            cb_vld_q <= 1'b0;
            nl_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            lk_q     <= lk_d;
            len_q    <= len_d;
            stride_q <= stride_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            enb_q    <= enb_d;
            done_q   <= done_d;
            vld_sr_q <= vld_sr_d;
            stage_q  <= stage_d;
            cb_dat_q <= cb_dat_d;
            nl_dat_q <= nl_dat_d;
            cb_vld_q <= cb_vld_d;
            nl_vld_q <= nl_vld_d;
        end
    end

    assign rd_busy     = (state_q != S_IDLE);
    assign rd_done     = done_q;
    assign TB_enb      = enb_q;
    assign TB_addrb    = addr_q;
    assign CB_dina     = cb_dat_q;
    assign CB_dina_vld = cb_vld_q;
    assign NL_din      = nl_dat_q;
    assign NL_din_vld  = nl_vld_q;

endmodule
